segre_mem_arbiter: RTL and testbench
====================================

SEGRE_MEM_ARBITER -- requirements
Module: segre_mem_arbiter

Interface
REQ-001 Parameter ADDR_SIZE, default 32, SHALL set the width of all address ports.
REQ-002 Parameter CACHE_LINE_SIZE, default 128, SHALL set the width of all line data ports.
REQ-003 clk_i  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rsn_i  in  1  SHALL be the reset, asynchronous and active-low.
REQ-005 ic_req_i  in  1  SHALL carry the I-cache line-fill request, held until granted.
REQ-006 ic_addr_i  in  ADDR_SIZE  SHALL carry the I-cache miss address.
REQ-007 ic_gnt_o  out  1  SHALL be a one-cycle grant pulse to the I-cache.
REQ-008 ic_rvalid_o / ic_rdata_o  out  1 / CACHE_LINE_SIZE  SHALL be the I-cache fill-complete pulse and line data.
REQ-009 dc_req_i, dc_we_i  in  1, 1  SHALL carry the D-cache request and write flag (1 = writeback, 0 = fill), held until granted.
REQ-010 dc_addr_i / dc_wdata_i  in  ADDR_SIZE / CACHE_LINE_SIZE  SHALL carry the D-cache address and writeback line.
REQ-011 dc_gnt_o, dc_rvalid_o / dc_rdata_o  out  1, 1 / CACHE_LINE_SIZE  SHALL be the D-cache grant pulse, completion pulse and fill data.
REQ-012 mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o  out  1, 1, ADDR_SIZE, CACHE_LINE_SIZE  SHALL drive the shared memory request.
REQ-013 mem_gnt_i, mem_rvalid_i, mem_rdata_i  in  1, 1, CACHE_LINE_SIZE  SHALL be memory accept, completion (reads and writes) and read data.
REQ-014 busy_o  out  1  SHALL be high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, WAIT, with at most one transaction outstanding.
REQ-016 In IDLE, when any request is present, the block SHALL select a winner, pulse its gnt in that same cycle, latch addr (low log2(CACHE_LINE_SIZE/8) bits forced to 0), we (0 for I-cache) and wdata, record the owner, and enter REQ.
REQ-017 In REQ, mem_req_o SHALL be 1 with mem_addr_o/mem_we_o/mem_wdata_o stable from the latched values until the cycle mem_gnt_i = 1; then enter WAIT.
REQ-018 In WAIT, the cycle mem_rvalid_i = 1 SHALL produce the owner's rvalid pulse combinationally, with mem_rdata_i routed to that owner's rdata; the FSM returns to IDLE.
REQ-019 Latency: request seen in IDLE cycle N -> gnt at N, mem_req_o at N+1; at least one IDLE cycle separates consecutive transactions.
REQ-020 mem_req_o SHALL be 0 in IDLE and WAIT; mem_rvalid_i outside WAIT SHALL be ignored (no rvalid pulse, no state change).
REQ-021 A non-owner's rvalid and gnt SHALL remain 0; rdata outputs SHALL be 0 when their rvalid is 0.
REQ-022 A request arriving during REQ/WAIT SHALL wait, and the request is arbitrated at the next IDLE cycle.
REQ-023 dc_rvalid_o on a writeback SHALL signal completion only; dc_rdata_o content is then don't-care, driven 0.

Reset
REQ-024 rsn_i low SHALL asynchronously force IDLE, all outputs 0 and the round-robin pointer to "last served = D-cache".
REQ-025 Reset mid-transaction SHALL abort it with no rvalid pulse; requesters re-request after reset.

Configuration
REQ-026 With SEGRE_MEM_ARB_RR_EN defined, simultaneous requests SHALL be granted to the requester not served last (pointer updated at each grant); without it, D-cache SHALL always win over I-cache.

Verification
REQ-027 Single I-fill: ic_req_i=1, ic_addr_i=0x0000_1234 -> ic_gnt_o pulse, mem_addr_o=0x0000_1230, mem_we_o=0; mem_rvalid_i with rdata 0xA5..A5 -> ic_rvalid_o=1, ic_rdata_o=0xA5..A5 for one cycle.
REQ-028 Writeback: dc_req_i=1, dc_we_i=1, dc_addr_i=0x8000_0040, dc_wdata_i=0x1122..FF, mem_gnt_i delayed 3 cycles -> mem_req_o held 4 cycles with stable payload, then dc_rvalid_o pulse on mem_rvalid_i.
REQ-029 Both requesting continuously from reset -> with macro: grants IC, DC, IC, DC; without macro: DC on every grant.
REQ-030 Spurious mem_rvalid_i=1 in IDLE and in REQ -> no rvalid pulse, state unchanged.
REQ-031 rsn_i pulsed low in WAIT -> busy_o=0, mem_req_o=0 immediately; following mem_rvalid_i produces no rvalid pulse.

Source files
------------

// File: rtl/segre_mem_arbiter.sv
// Two-requester memory arbiter: I-cache line fills and D-cache fills/writebacks share one memory
// port, one transaction at a time. Define SEGRE_MEM_ARB_RR_EN for round-robin, else D-cache wins.
module segre_mem_arbiter #(
   parameter int unsigned ADDR_SIZE       = 32,
   parameter int unsigned CACHE_LINE_SIZE = 128
) (
   input  logic                       clk_i,
   input  logic                       rsn_i,
   // I-cache side
   input  logic                       ic_req_i,
   input  logic [ADDR_SIZE-1:0]       ic_addr_i,
   output logic                       ic_gnt_o,
   output logic                       ic_rvalid_o,
   output logic [CACHE_LINE_SIZE-1:0] ic_rdata_o,
   // D-cache side
   input  logic                       dc_req_i,
   input  logic                       dc_we_i,
   input  logic [ADDR_SIZE-1:0]       dc_addr_i,
   input  logic [CACHE_LINE_SIZE-1:0] dc_wdata_i,
   output logic                       dc_gnt_o,
   output logic                       dc_rvalid_o,
   output logic [CACHE_LINE_SIZE-1:0] dc_rdata_o,
   // Memory side
   output logic                       mem_req_o,
   output logic                       mem_we_o,
   output logic [ADDR_SIZE-1:0]       mem_addr_o,
   output logic [CACHE_LINE_SIZE-1:0] mem_wdata_o,
   input  logic                       mem_gnt_i,
   input  logic                       mem_rvalid_i,
   input  logic [CACHE_LINE_SIZE-1:0] mem_rdata_i,
   output logic                       busy_o
);

   localparam int unsigned OffW = $clog2(CACHE_LINE_SIZE / 8);
   localparam logic [ADDR_SIZE-1:0] AddrMask = {ADDR_SIZE{1'b1}} << OffW;

   typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;
   typedef enum logic {OwnIc, OwnDc} owner_e;

   state_e                     state_q, state_d;
   owner_e                     owner_q, owner_d;
   logic                       we_q, we_d;
   logic [ADDR_SIZE-1:0]       addr_q, addr_d;
   logic [CACHE_LINE_SIZE-1:0] wdata_q, wdata_d;
   logic                       any_req;
   logic                       grant_dc;

   assign any_req = ic_req_i | dc_req_i;

`ifdef SEGRE_MEM_ARB_RR_EN
   // Remembers whether the D-cache was served last; ties go to the other requester.
   logic last_dc_q, last_dc_d;

   always_comb begin
      if (ic_req_i && dc_req_i) begin
         grant_dc = ~last_dc_q;
      end else begin
         grant_dc = dc_req_i;
      end
   end
`else
   assign grant_dc = dc_req_i;
`endif

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
`ifdef SEGRE_MEM_ARB_RR_EN
      last_dc_d   = last_dc_q;
`endif
      ic_gnt_o    = 1'b0;
      dc_gnt_o    = 1'b0;
      ic_rvalid_o = 1'b0;
      dc_rvalid_o = 1'b0;
      ic_rdata_o  = '0;
      dc_rdata_o  = '0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;

      unique case (state_q)
         StIdle: begin
            // Gate with reset so no grant leaks out while reset is held.
            if (any_req && rsn_i) begin
               state_d = StReq;
`ifdef SEGRE_MEM_ARB_RR_EN
               last_dc_d = grant_dc;
`endif
               if (grant_dc) begin
                  dc_gnt_o = 1'b1;
                  owner_d  = OwnDc;
                  addr_d   = dc_addr_i & AddrMask;
                  we_d     = dc_we_i;
                  wdata_d  = dc_wdata_i;
               end else begin
                  ic_gnt_o = 1'b1;
                  owner_d  = OwnIc;
                  addr_d   = ic_addr_i & AddrMask;
                  we_d     = 1'b0;
                  wdata_d  = '0;
               end
            end
         end
         StReq: begin
            mem_req_o   = 1'b1;
            mem_we_o    = we_q;
            mem_addr_o  = addr_q;
            mem_wdata_o = wdata_q;
            if (mem_gnt_i) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (mem_rvalid_i) begin
               state_d = StIdle;
               if (owner_q == OwnDc) begin
                  dc_rvalid_o = 1'b1;
                  // Writeback completion carries no data.
                  dc_rdata_o  = we_q ? '0 : mem_rdata_i;
               end else begin
                  ic_rvalid_o = 1'b1;
                  ic_rdata_o  = mem_rdata_i;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign busy_o = (state_q != StIdle);

   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         state_q   <= StIdle;
         owner_q   <= OwnIc;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
`ifdef SEGRE_MEM_ARB_RR_EN
         last_dc_q <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
`ifdef SEGRE_MEM_ARB_RR_EN
         last_dc_q <= last_dc_d;
`endif
      end
   end

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Self-checking bench for segre_mem_arbiter: directed transaction table, corner-case sequences
// and a randomized run against a transaction-level reference model.
module tb_segre_mem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned LW = 128;

   logic          clk_i = 1'b0;
   logic          rsn_i;
   logic          ic_req_i, ic_gnt_o, ic_rvalid_o;
   logic [AW-1:0] ic_addr_i;
   logic [LW-1:0] ic_rdata_o;
   logic          dc_req_i, dc_we_i, dc_gnt_o, dc_rvalid_o;
   logic [AW-1:0] dc_addr_i;
   logic [LW-1:0] dc_wdata_i, dc_rdata_o;
   logic          mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, busy_o;
   logic [AW-1:0] mem_addr_o;
   logic [LW-1:0] mem_wdata_o, mem_rdata_i;

   segre_mem_arbiter #(
      .ADDR_SIZE       (AW),
      .CACHE_LINE_SIZE (LW)
   ) dut (
      .clk_i        (clk_i),
      .rsn_i        (rsn_i),
      .ic_req_i     (ic_req_i),
      .ic_addr_i    (ic_addr_i),
      .ic_gnt_o     (ic_gnt_o),
      .ic_rvalid_o  (ic_rvalid_o),
      .ic_rdata_o   (ic_rdata_o),
      .dc_req_i     (dc_req_i),
      .dc_we_i      (dc_we_i),
      .dc_addr_i    (dc_addr_i),
      .dc_wdata_i   (dc_wdata_i),
      .dc_gnt_o     (dc_gnt_o),
      .dc_rvalid_o  (dc_rvalid_o),
      .dc_rdata_o   (dc_rdata_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .busy_o       (busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit            is_dc;
      bit            we;
      logic [AW-1:0] addr;
      logic [LW-1:0] wdata;
      logic [LW-1:0] rdata;
      int            gnt_dly;
      logic [AW-1:0] exp_addr;
      logic [LW-1:0] exp_rdata;
   } vec_t;

   vec_t vecs [4];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic smp();
      @(negedge clk_i);
   endtask

   function automatic logic [LW-1:0] r128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic clear_inputs();
      ic_req_i     = 1'b0;
      ic_addr_i    = '0;
      dc_req_i     = 1'b0;
      dc_we_i      = 1'b0;
      dc_addr_i    = '0;
      dc_wdata_i   = '0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rsn_i = 1'b0;
      cyc();
      cyc();
      rsn_i = 1'b1;
      cyc();
   endtask

   // One complete transaction from the table, checking every phase along the way.
   task automatic run_vec(input vec_t v);
      if (v.is_dc) begin
         dc_req_i   = 1'b1;
         dc_we_i    = v.we;
         dc_addr_i  = v.addr;
         dc_wdata_i = v.wdata;
      end else begin
         ic_req_i  = 1'b1;
         ic_addr_i = v.addr;
      end
      smp();
      chk("vec_gnt", LW'({ic_gnt_o, dc_gnt_o}), v.is_dc ? LW'(2'b01) : LW'(2'b10));
      chk("vec_idle_mreq", LW'({mem_req_o, busy_o}), LW'(2'b00));
      cyc();
      // Scramble the request payload to prove the DUT latched it.
      ic_req_i   = 1'b0;
      dc_req_i   = 1'b0;
      ic_addr_i  = $urandom;
      dc_addr_i  = $urandom;
      dc_wdata_i = r128();
      dc_we_i    = ~v.we;
      for (int d = 0; d <= v.gnt_dly; d++) begin
         mem_gnt_i = (d == v.gnt_dly);
         smp();
         chk("vec_mreq", LW'({mem_req_o, busy_o}), LW'(2'b11));
         chk("vec_maddr", LW'(mem_addr_o), LW'(v.exp_addr));
         chk("vec_mwe", LW'(mem_we_o), LW'(v.we));
         if (v.we) chk("vec_mwdata", mem_wdata_o, v.wdata);
         cyc();
      end
      mem_gnt_i = 1'b0;
      smp();
      chk("vec_wait", LW'({mem_req_o, busy_o, ic_rvalid_o, dc_rvalid_o}), LW'(4'b0100));
      cyc();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = v.rdata;
      smp();
      chk("vec_rvalid", LW'({ic_rvalid_o, dc_rvalid_o}), v.is_dc ? LW'(2'b01) : LW'(2'b10));
      chk("vec_rdata", v.is_dc ? dc_rdata_o : ic_rdata_o, v.exp_rdata);
      chk("vec_other_rdata", v.is_dc ? ic_rdata_o : dc_rdata_o, '0);
      cyc();
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      smp();
      chk("vec_done", LW'({busy_o, ic_rvalid_o, dc_rvalid_o}), LW'(3'b000));
      cyc();
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit            rr_en;
      bit            got [8];
      bit            exp_dc;
      bit            last_dc;
      int            n_gnt;
      bit            ic_pend, dc_pend, dc_w, t_dc, t_we, win_dc;
      logic [AW-1:0] ic_a, dc_a, t_addr;
      logic [LW-1:0] dc_d, t_wd, e_ic_rd, e_dc_rd;
      logic [5:0]    e_flags;
      int            ph, ph_n;

`ifdef SEGRE_MEM_ARB_RR_EN
      rr_en = 1'b1;
`else
      rr_en = 1'b0;
`endif

      vecs[0] = '{is_dc: 1'b0, we: 1'b0, addr: 32'h0000_1234, wdata: '0,
                  rdata: {4{32'hA5A5_A5A5}}, gnt_dly: 0, exp_addr: 32'h0000_1230,
                  exp_rdata: {4{32'hA5A5_A5A5}}};
      vecs[1] = '{is_dc: 1'b1, we: 1'b1, addr: 32'h8000_0040,
                  wdata: 128'h11223344556677889900AABBCCDDEEFF, rdata: {4{32'hFFFF_FFFF}},
                  gnt_dly: 3, exp_addr: 32'h8000_0040, exp_rdata: '0};
      vecs[2] = '{is_dc: 1'b1, we: 1'b0, addr: 32'h0000_ABCF, wdata: 128'h5,
                  rdata: {4{32'hDEAD_BEEF}}, gnt_dly: 1, exp_addr: 32'h0000_ABC0,
                  exp_rdata: {4{32'hDEAD_BEEF}}};
      vecs[3] = '{is_dc: 1'b0, we: 1'b0, addr: 32'hFFFF_FFFF, wdata: '0,
                  rdata: {4{32'h0123_4567}}, gnt_dly: 2, exp_addr: 32'hFFFF_FFF0,
                  exp_rdata: {4{32'h0123_4567}}};

      // Reset with every input active: all outputs must be quiet.
      clear_inputs();
      rsn_i        = 1'b0;
      ic_req_i     = 1'b1;
      dc_req_i     = 1'b1;
      dc_we_i      = 1'b1;
      mem_rvalid_i = 1'b1;
      mem_gnt_i    = 1'b1;
      mem_rdata_i  = r128();
      smp();
      chk("rst_flags", LW'({ic_gnt_o, dc_gnt_o, ic_rvalid_o, dc_rvalid_o, mem_req_o, mem_we_o,
                            busy_o}), '0);
      chk("rst_maddr", LW'(mem_addr_o), '0);
      chk("rst_mwdata", mem_wdata_o, '0);
      chk("rst_rdata", ic_rdata_o | dc_rdata_o, '0);
      do_reset();

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      // Spurious rvalid in idle.
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = r128();
      smp();
      chk("spur_idle", LW'({ic_rvalid_o, dc_rvalid_o, busy_o}), '0);
      chk("spur_idle_rdata", ic_rdata_o | dc_rdata_o, '0);
      cyc();
      mem_rvalid_i = 1'b0;
      smp();
      chk("spur_idle_after", LW'(busy_o), '0);
      cyc();

      // Spurious rvalid while the request is still waiting for mem_gnt_i.
      ic_req_i  = 1'b1;
      ic_addr_i = 32'h0000_2000;
      cyc();
      ic_req_i     = 1'b0;
      mem_rvalid_i = 1'b1;
      smp();
      chk("spur_req", LW'({ic_rvalid_o, dc_rvalid_o, mem_req_o}), LW'(3'b001));
      cyc();
      mem_rvalid_i = 1'b0;
      smp();
      chk("spur_req_after", LW'({mem_req_o, busy_o}), LW'(2'b11));

      // Reset while in REQ drops mem_req_o immediately.
      #1 rsn_i = 1'b0;
      #1;
      chk("rst_in_req", LW'({mem_req_o, busy_o}), '0);
      rsn_i = 1'b1;
      cyc();

      // Reset while in WAIT aborts the transaction.
      ic_req_i = 1'b1;
      cyc();
      ic_req_i  = 1'b0;
      mem_gnt_i = 1'b1;
      cyc();
      mem_gnt_i = 1'b0;
      smp();
      chk("wait_busy", LW'({mem_req_o, busy_o}), LW'(2'b01));
      #1 rsn_i = 1'b0;
      #1;
      chk("rst_in_wait", LW'({mem_req_o, busy_o}), '0);
      rsn_i = 1'b1;
      cyc();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = r128();
      smp();
      chk("rst_abort_rvalid", LW'({ic_rvalid_o, dc_rvalid_o, busy_o}), '0);
      cyc();
      mem_rvalid_i = 1'b0;

      // Both requesters hold their request continuously from reset.
      do_reset();
      rsn_i = 1'b0;
      cyc();
      ic_req_i     = 1'b1;
      dc_req_i     = 1'b1;
      ic_addr_i    = 32'h100;
      dc_addr_i    = 32'h200;
      mem_gnt_i    = 1'b1;
      mem_rvalid_i = 1'b1;
      rsn_i        = 1'b1;
      n_gnt        = 0;
      for (int c = 0; c < 30 && n_gnt < 4; c++) begin
         smp();
         if (ic_gnt_o || dc_gnt_o) begin
            chk("arb_single_gnt", LW'(ic_gnt_o & dc_gnt_o), '0);
            got[n_gnt] = dc_gnt_o;
            n_gnt++;
         end
         cyc();
      end
      chk("arb_count", LW'(n_gnt), LW'(4));
      last_dc = 1'b1;
      for (int i = 0; i < n_gnt; i++) begin
         exp_dc  = rr_en ? !last_dc : 1'b1;
         last_dc = exp_dc;
         chk("arb_order", LW'(got[i]), LW'(exp_dc));
      end

      // Randomized traffic against the transaction-level model.
      do_reset();
      ic_pend = 1'b0;
      dc_pend = 1'b0;
      last_dc = 1'b1;
      ph      = 0;
      t_dc    = 1'b0;
      t_we    = 1'b0;
      t_addr  = '0;
      t_wd    = '0;
      for (int c = 0; c < 800; c++) begin
         if (!ic_pend && $urandom_range(3) == 0) begin
            ic_pend = 1'b1;
            ic_a    = $urandom;
         end
         if (!dc_pend && $urandom_range(3) == 0) begin
            dc_pend = 1'b1;
            dc_a    = $urandom;
            dc_w    = 1'($urandom_range(1));
            dc_d    = r128();
         end
         ic_req_i     = ic_pend;
         ic_addr_i    = ic_pend ? ic_a : $urandom;
         dc_req_i     = dc_pend;
         dc_addr_i    = dc_pend ? dc_a : $urandom;
         dc_we_i      = dc_pend ? dc_w : 1'($urandom_range(1));
         dc_wdata_i   = dc_pend ? dc_d : r128();
         mem_gnt_i    = 1'($urandom_range(1));
         mem_rvalid_i = ($urandom_range(2) == 0);
         mem_rdata_i  = r128();
         smp();
         // e_flags = {ic_gnt, dc_gnt, ic_rvalid, dc_rvalid, mem_req, busy}
         e_flags = {4'b0000, 1'b0, ph != 0};
         e_ic_rd = '0;
         e_dc_rd = '0;
         ph_n    = ph;
         if (ph == 0) begin
            if (ic_pend || dc_pend) begin
               win_dc  = (ic_pend && dc_pend) ? (rr_en ? !last_dc : 1'b1) : dc_pend;
               last_dc = win_dc;
               e_flags[5:4] = win_dc ? 2'b01 : 2'b10;
               t_dc    = win_dc;
               t_we    = win_dc ? dc_w : 1'b0;
               t_addr  = win_dc ? ((dc_a >> 4) << 4) : ((ic_a >> 4) << 4);
               t_wd    = dc_d;
               if (win_dc) dc_pend = 1'b0;
               else        ic_pend = 1'b0;
               ph_n = 1;
            end
         end else if (ph == 1) begin
            e_flags[1] = 1'b1;
            chk("rnd_maddr", LW'(mem_addr_o), LW'(t_addr));
            chk("rnd_mwe", LW'(mem_we_o), LW'(t_we));
            if (t_we) chk("rnd_mwdata", mem_wdata_o, t_wd);
            if (mem_gnt_i) ph_n = 2;
         end else if (mem_rvalid_i) begin
            if (t_dc) begin
               e_flags[2] = 1'b1;
               e_dc_rd    = t_we ? '0 : mem_rdata_i;
            end else begin
               e_flags[3] = 1'b1;
               e_ic_rd    = mem_rdata_i;
            end
            ph_n = 0;
         end
         chk("rnd_flags", LW'({ic_gnt_o, dc_gnt_o, ic_rvalid_o, dc_rvalid_o, mem_req_o, busy_o}),
             LW'(e_flags));
         chk("rnd_ic_rdata", ic_rdata_o, e_ic_rd);
         chk("rnd_dc_rdata", dc_rdata_o, e_dc_rd);
         ph = ph_n;
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
